// File: rtl/mux_seq_nw.sv
// mux_seq_nw: registered N-channel, W-bit multiplexer with a valid/ready
// output handshake. Manual mode sends one beat from the selected channel.
// Scan mode sends channels 0..N-1 as a burst with no bubbles.
// Optional feature: define MUX_SEQ_PARITY_EN to add the registered
// even-parity output out_par.
module mux_seq_nw #(
    parameter int N = 16,
    parameter int W = 8,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in_data,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              start,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_err,
    output logic              busy,
    output logic              done
`ifdef MUX_SEQ_PARITY_EN
    ,
    output logic              out_par
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    // The channel count is one bit wider than an index, so that the
    // out-of-range test (idx >= N) can be done without overflow.
    localparam logic [SELW:0]   NUM  = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    state_t          state;
    state_t          state_next;
    logic [SELW-1:0] idx;
    logic [SELW-1:0] idx_next;
    logic            scan;
    logic            scan_next;
    logic [W-1:0]    data_next;
    logic            valid_next;
    logic            err_next;
    logic            done_next;
    logic            load;

    // Picks channel k from the flat input bus; indexes at or above N read as zero.
    function automatic logic [W-1:0] slice_of(input logic [SELW-1:0] k,
                                              input logic [N*W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(k) == i) begin
                r = d[i*W +: W];
            end
        end
        return r;
    endfunction

    // The beat index doubles as the reported channel number.
    assign out_ch = idx;
    assign busy   = (state != IDLE);

    // Next-state and next-beat logic. A beat is (re)loaded only when it is
    // created: on an accepted start, or on a scan handshake that is not the
    // last one, so a stalled beat is never disturbed by in_data changes.
    // DONE is held for two cycles: the first raises the registered done
    // flag, the second lets it be seen for exactly one cycle before IDLE.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        scan_next  = scan;
        data_next  = out_data;
        valid_next = out_valid;
        err_next   = out_err;
        done_next  = 1'b0;
        load       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    idx_next   = mode ? '0 : sel;
                    scan_next  = mode;
                    valid_next = 1'b1;
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_valid && out_ready) begin
                    if (!scan || idx == LAST) begin
                        valid_next = 1'b0;
                        state_next = DONE;
                    end else begin
                        idx_next = idx + 1'b1;
                        load     = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!done) begin
                    done_next = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            data_next = slice_of(idx_next, in_data);
            err_next  = ({1'b0, idx_next} >= NUM);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Beat datapath registers: index, scan flag and the output beat itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            scan      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            done      <= 1'b0;
        end else begin
            idx       <= idx_next;
            scan      <= scan_next;
            out_data  <= data_next;
            out_valid <= valid_next;
            out_err   <= err_next;
            done      <= done_next;
        end
    end

`ifdef MUX_SEQ_PARITY_EN
    // Parity tracks the data register, so it is held whenever the beat is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_par <= 1'b0;
        end else begin
            out_par <= ^data_next;
        end
    end
`endif

endmodule

// File: tb/tb_mux_seq_nw.sv
// tb_mux_seq_nw: self-checking bench for mux_seq_nw with N=10, W=8.
// Each request is modelled as a list of expected channels; the data for a
// beat is taken from in_data as driven for the edge that creates the beat.
module tb_mux_seq_nw;

    localparam int N    = 10;
    localparam int W    = 8;
    localparam int SELW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*W-1:0]    in_data;
    logic [SELW-1:0]   sel;
    logic              mode;
    logic              start;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              out_err;
    logic              busy;
    logic              done;
`ifdef MUX_SEQ_PARITY_EN
    logic              out_par;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_seq_nw #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .mode      (mode),
        .start     (start),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err),
        .busy      (busy),
        .done      (done)
`ifdef MUX_SEQ_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference value of channel k: plain shift of the flat bus, zero past N-1.
    function automatic logic [W-1:0] chan_val(input logic [N*W-1:0] d, input int k);
        if (k >= N) return '0;
        return W'(d >> (k * W));
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = W'($urandom);
        end
    endtask

    // Issues one request from IDLE (called at a negative edge with in_data
    // already set) and follows it to IDLE, checking every beat and the done pulse.
    task automatic run_request(input logic m, input logic [SELW-1:0] s,
                               input int stall_beat, input int stall_len,
                               input logic poke_start, input string tag);
        int           chs[$];
        int           b;
        int           stalls;
        int           cyc;
        logic [W-1:0] exp_d;
        logic         rdy;

        if (m) begin
            for (int k = 0; k < N; k++) chs.push_back(k);
        end else begin
            chs.push_back(int'(s));
        end

        check({tag, "/idle"}, busy, 0);
        mode      = m;
        sel       = s;
        start     = 1'b1;
        out_ready = 1'(($urandom));
        exp_d     = chan_val(in_data, chs[0]);
        @(negedge clk);
        start = 1'b0;

        b = 0;
        stalls = 0;
        cyc = 0;
        while (b < chs.size() && cyc < 4 * N + 20) begin
            check({tag, "/valid"}, out_valid, 1);
            check({tag, "/ch"}, out_ch, chs[b]);
            check({tag, "/data"}, out_data, exp_d);
            check({tag, "/err"}, out_err, (chs[b] >= N));
            check({tag, "/busy"}, busy, 1);
            check({tag, "/done_early"}, done, 0);
`ifdef MUX_SEQ_PARITY_EN
            check({tag, "/par"}, out_par, ^exp_d);
`endif
            rdy = !(b == stall_beat && stalls < stall_len);
            if (!rdy) stalls++;
            out_ready = rdy;
            rand_data();
            if (poke_start) begin
                start = 1'(($urandom));
                sel   = SELW'($urandom);
                mode  = 1'(($urandom));
            end
            if (rdy) begin
                b++;
                if (b < chs.size()) exp_d = chan_val(in_data, chs[b]);
            end
            cyc++;
            @(negedge clk);
        end
        check({tag, "/beats"}, b, chs.size());
        check({tag, "/stall_cycles"}, stalls, stall_len);

        // Last handshake done: one cycle of DONE before the pulse.
        check({tag, "/valid_off"}, out_valid, 0);
        check({tag, "/busy_pre"}, busy, 1);
        check({tag, "/done_pre"}, done, 0);
        @(negedge clk);
        check({tag, "/done_pulse"}, done, 1);
        check({tag, "/busy_pulse"}, busy, 1);
        @(negedge clk);
        start = 1'b0;
        check({tag, "/done_post"}, done, 0);
        check({tag, "/busy_post"}, busy, 0);
        check({tag, "/valid_post"}, out_valid, 0);
    endtask

    initial begin
        int cyc;

        rst       = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        in_data   = '0;

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        check("reset/data", out_data, 0);
        check("reset/ch", out_ch, 0);
        check("reset/valid", out_valid, 0);
        check("reset/err", out_err, 0);
        check("reset/busy", busy, 0);
        check("reset/done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset/idle_busy", busy, 0);

        // Manual beat from channel 5 holding 0xA5.
        rand_data();
        in_data[5*W +: W] = 8'hA5;
        run_request(1'b0, 4'd5, -1, 0, 1'b0, "manual5");

        // Full scan, known pattern on the first channels, no backpressure.
        rand_data();
        in_data[0*W +: W] = 8'h11;
        in_data[1*W +: W] = 8'h22;
        in_data[2*W +: W] = 8'h33;
        in_data[3*W +: W] = 8'h44;
        run_request(1'b1, 4'd0, -1, 0, 1'b0, "scan");

        // Scan stalled on beat 2 for three cycles, in_data changing meanwhile,
        // with start pulsed while busy.
        rand_data();
        in_data[2*W +: W] = 8'h33;
        run_request(1'b1, 4'd7, 2, 3, 1'b1, "scan_stall");

        // Out-of-range manual index, start pulsed while busy.
        rand_data();
        run_request(1'b0, 4'd12, 0, 2, 1'b1, "oor12");

        // Last in-range index.
        rand_data();
        run_request(1'b0, 4'd9, -1, 0, 1'b0, "manual9");

        // Reset in the middle of a scan at beat 2.
        rand_data();
        mode      = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (out_ch != 4'd2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid/reach_beat2", out_ch, 2);
        #2 rst = 1'b1;
        #1;
        check("rst_mid/data", out_data, 0);
        check("rst_mid/ch", out_ch, 0);
        check("rst_mid/valid", out_valid, 0);
        check("rst_mid/err", out_err, 0);
        check("rst_mid/busy", busy, 0);
        check("rst_mid/done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid/no_done", done, 0);
            check("rst_mid/stay_idle", busy, 0);
        end
        rand_data();
        run_request(1'b1, 4'd3, -1, 0, 1'b0, "rst_rescan");

        // Randomized requests with random stalls.
        for (int r = 0; r < 8; r++) begin
            rand_data();
            run_request(1'((($urandom))), SELW'($urandom_range(0, 15)),
                        $urandom_range(0, N - 1), $urandom_range(0, 3),
                        1'b1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
